// File: rtl/serial_fa_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop process WIDTH bits LSB-first.
// Define SERIAL_FA_ADD_SUB_EN to add a 'sub' input selecting a-b instead of a+b+cin.
module serial_fa_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_FA_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nx;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_FA_ADD_SUB_EN
    // Subtraction is a + ~b + 1; the forced carry-in replaces cin.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    assign fa_s   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c   = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign res_nx = {fa_s, res_sr};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= fa_c;
            res_sr <= res_nx[WIDTH-1:1];
            cnt    <= cnt + 1'b1;
            // Outputs move only on the edge that enters DONE, so they hold between results.
            if (last) begin
                sum  <= res_nx;
                cout <= fa_c;
            end
        end
    end

endmodule
